uart_rx_frame_ctrl: RTL and testbench

Frame controller for the UART receiver. It detects the start bit, times every bit period with an internal edge/bit counter, and sequences the neighbouring RX stages: data sampler, deserializer, start checker, parity checker and stop checker. It emits the per-bit enable pulses those stages need, collects their error flags, and qualifies each received frame with a one-cycle data_valid or frame_err pulse.

---
 rtl/uart_rx_frame_ctrl_pkg.sv | 17 +
 rtl/uart_rx_frame_ctrl_if.sv | 49 ++++
 rtl/uart_rx_frame_ctrl_edge_bit_counter.sv | 68 ++++++
 rtl/uart_rx_frame_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types and constants for the UART receive frame controller.
// Optional feature macro used by this slice: UART_RX_ERR_CNT_EN.
package uart_rx_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESCALE_W_DEF = 6;
  localparam int PRESCALE_MIN   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Bus between the frame controller and its neighbouring RX stages.
// With UART_RX_ERR_CNT_EN defined the bus also carries err_cnt_clr/err_cnt.
interface uart_rx_frame_ctrl_if
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  dat_samp_en;
  logic                  deser_en;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;
  logic                  frame_err;
`ifdef UART_RX_ERR_CNT_EN
  logic                  err_cnt_clr;
  logic [7:0]            err_cnt;

  modport master (
    output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err, err_cnt_clr,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
           stp_chk_en, data_valid, frame_err, err_cnt
  );
  modport slave (
    input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err, err_cnt_clr,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
           stp_chk_en, data_valid, frame_err, err_cnt
  );
`else
  modport master (
    output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
           stp_chk_en, data_valid, frame_err
  );
  modport slave (
    input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
           stp_chk_en, data_valid, frame_err
  );
`endif
endinterface

// File: rtl/uart_rx_frame_ctrl_edge_bit_counter.sv
// Bit-period timer: owns edge_cnt, bit_cnt and the latched (clamped)
// prescale, and decodes the strobe point (P-2) and end of bit (P-1).
module uart_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,     // frame start: latch prescale, zero edge_cnt
  input  logic                  active_i,    // FSM outside IDLE
  input  logic                  bit_clr_i,   // entering DATA
  input  logic                  bit_inc_i,   // next data bit
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic [3:0]            bit_cnt_o,
  output logic                  end_bit_o,
  output logic                  strobe_pt_o
);
  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(PRESCALE_MIN);
  localparam logic [PRESCALE_W-1:0] ONE   = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO   = PRESCALE_W'(2);

  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [3:0]            bit_q, bit_d;

  assign end_bit_o   = (edge_q == (prescale_q - ONE));
  assign strobe_pt_o = (edge_q == (prescale_q - TWO));
  assign edge_cnt_o  = edge_q;
  assign bit_cnt_o   = bit_q;

  // Next-state for the prescale latch, edge counter and bit counter.
  always_comb begin
    prescale_d = prescale_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    if (start_i) begin
      prescale_d = (prescale_i < P_MIN) ? P_MIN : prescale_i;
      edge_d     = '0;
    end else if (active_i) begin
      edge_d = end_bit_o ? '0 : (edge_q + ONE);
    end else begin
      edge_d = '0;
    end
    if (bit_clr_i) begin
      bit_d = 4'd0;
    end else if (bit_inc_i) begin
      bit_d = bit_q + 4'd1;
    end else begin
      bit_d = bit_q;
    end
  end

  // Counter and prescale registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prescale_q <= '0;
      edge_q     <= '0;
      bit_q      <= 4'd0;
    end else begin
      prescale_q <= prescale_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: start detection, per-bit strobes for the RX
// stages, error collection and one-cycle data_valid / frame_err result.
// Optional macro UART_RX_ERR_CNT_EN adds a saturating 8-bit error counter.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input logic                CLK,
  input logic                RST,
  uart_rx_frame_ctrl_if.slave bus
);
  rx_state_e             state_q, state_d;
  logic                  par_en_q, par_en_d;
  logic                  sticky_q, sticky_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  start_s, bit_clr_s, bit_inc_s;
  logic                  end_bit_s, strobe_pt_s, active_s;
  logic [PRESCALE_W-1:0] edge_cnt_s;
  logic [3:0]            bit_cnt_s;

  assign active_s = (state_q != IDLE);

  uart_edge_bit_counter #(.PRESCALE_W(PRESCALE_W)) u_cnt (
    .clk_i       (CLK),
    .rst_n_i     (RST),
    .start_i     (start_s),
    .active_i    (active_s),
    .bit_clr_i   (bit_clr_s),
    .bit_inc_i   (bit_inc_s),
    .prescale_i  (bus.Prescale),
    .edge_cnt_o  (edge_cnt_s),
    .bit_cnt_o   (bit_cnt_s),
    .end_bit_o   (end_bit_s),
    .strobe_pt_o (strobe_pt_s)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state; a low line at the edge that ends STOP starts the next
  // frame straight away so back-to-back frames lose no cycle.
  always_comb begin
    state_d   = state_q;
    start_s   = 1'b0;
    bit_clr_s = 1'b0;
    bit_inc_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.RX_IN) begin
          state_d = START;
          start_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (end_bit_s) begin
          if (bus.strt_glitch) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_clr_s = 1'b1;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (end_bit_s) begin
          if (bit_cnt_s == 4'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_inc_s = 1'b1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (end_bit_s) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (end_bit_s) begin
          if (!bus.RX_IN) begin
            state_d = START;
            start_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: strobes decoded from state and the bit-period position.
  always_comb begin
    bus.dat_samp_en = active_s;
    bus.strt_chk_en = (state_q == START)  && strobe_pt_s;
    bus.deser_en    = (state_q == DATA)   && strobe_pt_s;
    bus.par_chk_en  = (state_q == PARITY) && strobe_pt_s;
    bus.stp_chk_en  = (state_q == STOP)   && strobe_pt_s;
    bus.edge_cnt    = edge_cnt_s;
    bus.bit_cnt     = bit_cnt_s;
    bus.data_valid  = data_valid_q;
    bus.frame_err   = frame_err_q;
  end

  // Frame datapath next-state: PAR_EN latch, sticky parity error, result pulses.
  always_comb begin
    par_en_d     = start_s ? bus.PAR_EN : par_en_q;
    sticky_d     = sticky_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if ((state_q == PARITY) && end_bit_s) begin
      sticky_d = sticky_q | bus.par_err;
    end else if ((state_q == STOP) && end_bit_s) begin
      sticky_d     = 1'b0;
      data_valid_d = !bus.stp_err && !sticky_q;
      frame_err_d  = bus.stp_err || sticky_q;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Frame datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q     <= 1'b0;
      sticky_q     <= 1'b0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      par_en_q     <= par_en_d;
      sticky_q     <= sticky_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic       glitch_abort_s;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign glitch_abort_s = (state_q == START) && end_bit_s && bus.strt_glitch;
  assign bus.err_cnt    = err_cnt_q;

  // Error counter next-state: clear wins, otherwise saturating increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.err_cnt_clr) begin
      err_cnt_d = 8'd0;
    end else if ((frame_err_d || glitch_abort_s) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed and random frames
// checked cycle by cycle against a slot/phase model of the frame.
module tb_uart_rx_frame_ctrl;
  import uart_rx_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_errs = 0;

  always #5 CLK = ~CLK;

  uart_rx_frame_ctrl_if #(.PRESCALE_W(PW)) bus ();

  uart_rx_frame_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // One frame. c counts cycles after the start edge E0; t = P * slots.
  // pulse: 2'b10 = data_valid, 2'b01 = frame_err, 2'b00 = none.
  task automatic run_frame(input int pre, input logic par_en, input logic [7:0] data,
                           input logic glitch, input logic perr, input logic serr,
                           input logic b2b, input logic [1:0] prev_pulse, input int cut,
                           output logic [1:0] pulse);
    int p, nb, t, s, ph, last, k, sk;
    logic [6:0] exp_v, got_v;
    logic pt, ln;
    p  = (pre < PRESCALE_MIN) ? PRESCALE_MIN : pre;
    nb = glitch ? 1 : (DW + 2 + (par_en ? 1 : 0));
    t  = p * nb;
    pulse = glitch ? 2'b00 : (((par_en && perr) || serr) ? 2'b01 : 2'b10);
    if (cut < 0 && (glitch || pulse == 2'b01)) exp_errs++;
    bus.RX_IN    = 1'b0;
    bus.Prescale = PW'(pre);
    bus.PAR_EN   = par_en;
    last = b2b ? t - 1 : t + 1;
    if (cut >= 0) last = cut;
    for (int c = 0; c <= last; c++) begin
      @(negedge CLK);
      s  = c / p;
      ph = c % p;
      pt = (ph == p - 2);
      exp_v = 7'd0;
      if (c < t) begin
        exp_v[6] = 1'b1;
        exp_v[5] = (s == 0) && pt;
        exp_v[4] = (s >= 1) && (s <= DW) && pt;
        exp_v[3] = par_en && (s == DW + 1) && pt;
        exp_v[2] = !glitch && (s == nb - 1) && pt;
      end
      if (c == 0)      exp_v[1:0] = prev_pulse;
      else if (c == t) exp_v[1:0] = pulse;
      got_v = {bus.dat_samp_en, bus.strt_chk_en, bus.deser_en, bus.par_chk_en,
               bus.stp_chk_en, bus.data_valid, bus.frame_err};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs P=%0d c=%0d got %b exp %b (samp,strt,deser,par,stp,dv,fe)",
                 p, c, got_v, exp_v);
      end
      checks++;
      if (bus.edge_cnt !== PW'((c < t) ? ph : 0)) begin
        errors++;
        $display("FAIL edge_cnt P=%0d c=%0d got %0d exp %0d", p, c, bus.edge_cnt,
                 (c < t) ? ph : 0);
      end
      if (c < t && s >= 1 && s <= DW) begin
        checks++;
        if (bus.bit_cnt !== 4'(s - 1)) begin
          errors++;
          $display("FAIL bit_cnt c=%0d got %0d exp %0d", c, bus.bit_cnt, s - 1);
        end
      end
      // Line value sampled at edge E(c+1); mid-frame config noise must be ignored.
      k  = c + 1;
      sk = k / p;
      if (k >= t)           ln = !(b2b && k == t);
      else if (glitch)      ln = 1'b1;
      else if (sk == 0)     ln = 1'b0;
      else if (sk <= DW)    ln = data[sk-1];
      else if (par_en && sk == DW + 1) ln = (^data) ^ perr;
      else                  ln = !serr;
      bus.RX_IN       = ln;
      bus.strt_glitch = glitch;
      bus.par_err     = perr;
      bus.stp_err     = serr;
      bus.Prescale    = PW'($urandom_range(0, 63));
      bus.PAR_EN      = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    logic [6:0] got_v;
    bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.Prescale = PW'(8);
    bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;
`ifdef UART_RX_ERR_CNT_EN
    bus.err_cnt_clr = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      got_v = {bus.dat_samp_en, bus.strt_chk_en, bus.deser_en, bus.par_chk_en,
               bus.stp_chk_en, bus.data_valid, bus.frame_err};
      checks++;
      if (got_v !== 7'd0 || bus.edge_cnt !== PW'(0) || bus.bit_cnt !== 4'd0) begin
        errors++;
        $display("FAIL reset_idle i=%0d got out=%b edge=%0d bit=%0d exp all 0",
                 i, got_v, bus.edge_cnt, bus.bit_cnt);
      end
    end
  endtask

  task automatic test_directed();
    logic [1:0] pl, pl2;
    run_frame(8,  1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, pl);  // good frame, dv at E88
    run_frame(8,  1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, -1, pl);  // start glitch, idle at E8
    run_frame(16, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, pl);  // no parity, dv at E160
    run_frame(8,  1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, -1, pl);  // parity error
    run_frame(8,  1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, -1, pl);  // stop error, b2b
    run_frame(8,  1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, pl,    -1, pl2); // frame_err at its c=0
    run_frame(2,  1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, pl);  // prescale clamp to 4
  endtask

  task automatic test_random();
    int tbl[6] = '{2, 4, 8, 16, 32, 5};
    logic [1:0] prev, pl;
    logic g, b;
    prev = 2'b00;
    for (int i = 0; i < 24; i++) begin
      g = ($urandom_range(0, 5) == 0);
      b = !g && (i < 23) && ($urandom_range(0, 1) == 1);
      run_frame(tbl[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), 8'($urandom),
                g, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), b, prev, -1, pl);
      prev = b ? pl : 2'b00;
    end
  endtask

`ifdef UART_RX_ERR_CNT_EN
  task automatic test_err_cnt();
    checks++;
    if (bus.err_cnt !== 8'(exp_errs > 255 ? 255 : exp_errs)) begin
      errors++;
      $display("FAIL err_cnt got %0d exp %0d", bus.err_cnt, exp_errs);
    end
    bus.err_cnt_clr = 1'b1;
    @(negedge CLK);
    bus.err_cnt_clr = 1'b0;
    exp_errs = 0;
    checks++;
    if (bus.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL err_cnt_clr got %0d exp 0", bus.err_cnt);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [1:0] pl;
    logic [6:0] got_v;
    run_frame(8, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 35, pl);  // stop inside bit 3
    #2 RST = 1'b0;
    #1;
    got_v = {bus.dat_samp_en, bus.strt_chk_en, bus.deser_en, bus.par_chk_en,
             bus.stp_chk_en, bus.data_valid, bus.frame_err};
    checks++;
    if (got_v !== 7'd0 || bus.edge_cnt !== PW'(0) || bus.bit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid got out=%b edge=%0d bit=%0d exp all 0",
               got_v, bus.edge_cnt, bus.bit_cnt);
    end
    exp_errs = 0;
    bus.RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    run_frame(8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, pl);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
`ifdef UART_RX_ERR_CNT_EN
    test_err_cnt();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
